// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin data-bus controller for the rv32 RAM, ROM port B and peripheral window.
// One transaction in flight; every grant produces exactly one response pulse to its owner.
module mem_bus_arbiter #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] ROM_BASE = 32'h0000_0000,
    parameter int unsigned     ROM_AW   = 18,
    parameter logic [XLEN-1:0] RAM_BASE = 32'h1000_0000,
    parameter int unsigned     RAM_AW   = 17,
    parameter logic [XLEN-1:0] PER_BASE = 32'h2000_0000,
    parameter int unsigned     PER_AW   = 12,
    parameter int unsigned     TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [XLEN-1:0]     m0_addr,
    input  logic [XLEN/8-1:0]   m0_byteen,
    input  logic [XLEN-1:0]     m0_wdata,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [XLEN-1:0]     m0_rdata,
    output logic                m0_err,
    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [XLEN-1:0]     m1_addr,
    input  logic [XLEN/8-1:0]   m1_byteen,
    input  logic [XLEN-1:0]     m1_wdata,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [XLEN-1:0]     m1_rdata,
    output logic                m1_err,
    output logic [RAM_AW-3:0]   ram_addr,
    output logic                ram_we,
    output logic [XLEN/8-1:0]   ram_byteen,
    output logic [XLEN-1:0]     ram_wdata,
    input  logic [XLEN-1:0]     ram_rdata,
    output logic [ROM_AW-3:0]   rom_addr,
    output logic                rom_rden,
    input  logic [XLEN-1:0]     rom_rdata,
    output logic                per_req,
    output logic                per_we,
    output logic [PER_AW-1:0]   per_addr,
    output logic [XLEN/8-1:0]   per_byteen,
    output logic [XLEN-1:0]     per_wdata,
    input  logic                per_ready,
    input  logic [XLEN-1:0]     per_rdata
);

    localparam int unsigned BW = XLEN / 8;

    typedef enum logic [1:0] {IDLE, RESP, PWAIT} state_t;
    typedef enum logic [1:0] {TGT_NONE, TGT_RAM, TGT_ROM, TGT_PER} tgt_t;

    state_t            state_q, state_d;
    tgt_t              tgt_q, tgt_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic              err_q, err_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [PER_AW-1:0] per_addr_q, per_addr_d;
    logic              per_we_q, per_we_d;
    logic [BW-1:0]     per_byteen_q, per_byteen_d;
    logic [XLEN-1:0]   per_wdata_q, per_wdata_d;
    logic [XLEN-1:0]   per_rdata_q, per_rdata_d;

    logic              sel, any_req;
    logic              s_we;
    logic [XLEN-1:0]   s_addr, s_wdata;
    logic [BW-1:0]     s_byteen;
    logic              hit_ram, hit_rom, hit_per, acc_err;
    logic              gnt_any, in_resp;
    logic [XLEN-1:0]   resp_data;

    // On a tie the master that did not win last time goes first.
    always_comb begin
        any_req  = m0_req | m1_req;
        sel      = (m0_req && m1_req) ? ~last_q : m1_req;
        s_we     = sel ? m1_we     : m0_we;
        s_addr   = sel ? m1_addr   : m0_addr;
        s_byteen = sel ? m1_byteen : m0_byteen;
        s_wdata  = sel ? m1_wdata  : m0_wdata;
        hit_ram  = s_addr[XLEN-1:RAM_AW] == RAM_BASE[XLEN-1:RAM_AW];
        hit_rom  = s_addr[XLEN-1:ROM_AW] == ROM_BASE[XLEN-1:ROM_AW];
        hit_per  = s_addr[XLEN-1:PER_AW] == PER_BASE[XLEN-1:PER_AW];
        acc_err  = (s_addr[1:0] != 2'b00) || !(hit_ram || hit_rom || hit_per)
                || (hit_rom && !hit_ram && s_we) || (s_we && s_byteen == '0);
    end

    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        last_d       = last_q;
        owner_d      = owner_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        per_addr_d   = per_addr_q;
        per_we_d     = per_we_q;
        per_byteen_d = per_byteen_q;
        per_wdata_d  = per_wdata_q;
        per_rdata_d  = per_rdata_q;
        gnt_any      = 1'b0;
        ram_we       = 1'b0;
        rom_rden     = 1'b0;
        ram_addr     = s_addr[RAM_AW-1:2];
        rom_addr     = s_addr[ROM_AW-1:2];
        ram_byteen   = s_byteen;
        ram_wdata    = s_wdata;

        unique case (state_q)
            IDLE: begin
                if (any_req && !rst) begin
                    gnt_any = 1'b1;
                    last_d  = sel;
                    owner_d = sel;
                    err_d   = acc_err;
                    tgt_d   = TGT_NONE;
                    state_d = RESP;
                    if (!acc_err) begin
                        if (hit_ram) begin
                            ram_we = s_we;
                            if (!s_we) tgt_d = TGT_RAM;
                        end else if (hit_rom) begin
                            rom_rden = 1'b1;
                            tgt_d    = TGT_ROM;
                        end else begin
                            per_addr_d   = s_addr[PER_AW-1:0];
                            per_we_d     = s_we;
                            per_byteen_d = s_byteen;
                            per_wdata_d  = s_wdata;
                            cnt_d        = '0;
                            state_d      = PWAIT;
                        end
                    end
                end
            end
            RESP: state_d = IDLE;
            PWAIT: begin
                if (per_ready) begin
                    if (!per_we_q) begin
                        per_rdata_d = per_rdata;
                        tgt_d       = TGT_PER;
                    end
                    cnt_d   = '0;
                    state_d = RESP;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            tgt_q        <= TGT_NONE;
            last_q       <= 1'b1;
            owner_q      <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            per_addr_q   <= '0;
            per_we_q     <= 1'b0;
            per_byteen_q <= '0;
            per_wdata_q  <= '0;
            per_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            last_q       <= last_d;
            owner_q      <= owner_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            per_addr_q   <= per_addr_d;
            per_we_q     <= per_we_d;
            per_byteen_q <= per_byteen_d;
            per_wdata_q  <= per_wdata_d;
            per_rdata_q  <= per_rdata_d;
        end
    end

    // Slave read data arrives one cycle after its strobe, i.e. during RESP.
    always_comb begin
        unique case (tgt_q)
            TGT_RAM: resp_data = ram_rdata;
            TGT_ROM: resp_data = rom_rdata;
            TGT_PER: resp_data = per_rdata_q;
            default: resp_data = '0;
        endcase
    end

    assign in_resp    = (state_q == RESP);
    assign m0_gnt     = gnt_any && !sel;
    assign m1_gnt     = gnt_any && sel;
    assign m0_rvalid  = in_resp && !owner_q;
    assign m1_rvalid  = in_resp && owner_q;
    assign m0_err     = m0_rvalid && err_q;
    assign m1_err     = m1_rvalid && err_q;
    assign m0_rdata   = m0_rvalid ? resp_data : '0;
    assign m1_rdata   = m1_rvalid ? resp_data : '0;

    assign per_req    = (state_q == PWAIT);
    assign per_we     = per_we_q;
    assign per_addr   = per_addr_q;
    assign per_byteen = per_byteen_q;
    assign per_wdata  = per_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table for single-cycle accesses,
// hand sequences for round-robin, peripheral wait/timeout and reset mid-transaction.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_byteen, m1_byteen;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [3:0]  ram_byteen;
    logic [31:0] ram_wdata, ram_rdata;
    logic [15:0] rom_addr;
    logic        rom_rden;
    logic [31:0] rom_rdata;
    logic        per_req, per_we, per_ready;
    logic [11:0] per_addr;
    logic [3:0]  per_byteen;
    logic [31:0] per_wdata, per_rdata;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_byteen(m0_byteen), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_byteen(m1_byteen), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_byteen(ram_byteen), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .rom_addr(rom_addr), .rom_rden(rom_rden), .rom_rdata(rom_rdata),
        .per_req(per_req), .per_we(per_we), .per_addr(per_addr), .per_byteen(per_byteen),
        .per_wdata(per_wdata), .per_ready(per_ready), .per_rdata(per_rdata)
    );

    typedef struct {
        string       name;
        logic        mst;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  byteen;
        logic [31:0] wdata;
        int          tgt;       // 0 none, 1 RAM, 2 ROM: which address bus to check
        logic [15:0] waddr;
        logic        ram_we;
        logic        rom_rden;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        logic        mst;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    localparam int NV = 11;
    vec_t vecs[NV];
    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic mst, input logic we, input logic [31:0] addr,
                                input logic [3:0] be, input logic [31:0] wd, input int tgt,
                                input logic [15:0] wa, input logic rwe, input logic rrd,
                                input logic [31:0] rd, input logic err);
        vec_t v;
        v.name = nm; v.mst = mst; v.we = we; v.addr = addr; v.byteen = be; v.wdata = wd;
        v.tgt = tgt; v.waddr = wa; v.ram_we = rwe; v.rom_rden = rrd; v.rdata = rd; v.err = err;
        return v;
    endfunction

    task automatic drive(input logic mst, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
        if (mst) begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_byteen = be; m1_wdata = wd;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_byteen = be; m0_wdata = wd;
        end
    endtask

    task automatic release_all();
        m0_req = 1'b0; m1_req = 1'b0;
        m0_we = 1'b0; m1_we = 1'b0;
    endtask

    task automatic push(input logic mst, input logic [31:0] rd, input logic err);
        exp_t e;
        e.mst = mst; e.rdata = rd; e.err = err;
        exp_q.push_back(e);
    endtask

    // Response scoreboard: every rvalid must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (m0_rvalid === 1'b1 || m1_rvalid === 1'b1) begin
                if (exp_q.size() == 0 || (m0_rvalid && m1_rvalid)) begin
                    n_chk++; n_fail++;
                    $display("FAIL resp_unexpected: m0_rvalid=%b m1_rvalid=%b, expected no response",
                             m0_rvalid, m1_rvalid);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_owner", {31'b0, m1_rvalid}, {31'b0, e.mst});
                    chk("resp_rdata", e.mst ? m1_rdata : m0_rdata, e.rdata);
                    chk("resp_err", {31'b0, e.mst ? m1_err : m0_err}, {31'b0, e.err});
                end
            end else begin
                chk("idle_quiet", m0_rdata | m1_rdata | {30'b0, m0_err, m1_err}, 32'h0);
            end
        end
    end

    initial begin
        vecs[0]  = mk("ram_rd",     0, 0, 32'h1000_0004, 4'hF, 32'h0,         1, 16'h0001, 0, 0, 32'hDEAD_BEEF, 0);
        vecs[1]  = mk("rom_rd",     1, 0, 32'h0000_0010, 4'hF, 32'h0,         2, 16'h0004, 0, 1, 32'hCAFE_0001, 0);
        vecs[2]  = mk("rom_wr",     1, 1, 32'h0000_0000, 4'hF, 32'h1111_1111, 0, 16'h0000, 0, 0, 32'h0,         1);
        vecs[3]  = mk("unmapped",   0, 0, 32'h3000_0000, 4'hF, 32'h0,         0, 16'h0000, 0, 0, 32'h0,         1);
        vecs[4]  = mk("misalign",   0, 0, 32'h1000_0002, 4'hF, 32'h0,         0, 16'h0000, 0, 0, 32'h0,         1);
        vecs[5]  = mk("ram_wr",     0, 1, 32'h1000_0008, 4'h3, 32'hABCD_0123, 1, 16'h0002, 1, 0, 32'h0,         0);
        vecs[6]  = mk("be_zero",    1, 1, 32'h1000_000C, 4'h0, 32'h5555_5555, 0, 16'h0000, 0, 0, 32'h0,         1);
        vecs[7]  = mk("ram_top",    1, 0, 32'h1001_FFFC, 4'hF, 32'h0,         1, 16'h7FFF, 0, 0, 32'hDEAD_BEEF, 0);
        vecs[8]  = mk("ram_above",  0, 0, 32'h1002_0000, 4'hF, 32'h0,         0, 16'h0000, 0, 0, 32'h0,         1);
        vecs[9]  = mk("rom_top",    0, 0, 32'h0003_FFFC, 4'hF, 32'h0,         2, 16'hFFFF, 0, 1, 32'hCAFE_0001, 0);
        vecs[10] = mk("per_unalgn", 1, 1, 32'h2000_0001, 4'hF, 32'h0,         0, 16'h0000, 0, 0, 32'h0,         1);

        rst = 1'b1;
        release_all();
        m0_addr = '0; m1_addr = '0; m0_byteen = '0; m1_byteen = '0; m0_wdata = '0; m1_wdata = '0;
        ram_rdata = 32'hDEAD_BEEF; rom_rdata = 32'hCAFE_0001;
        per_ready = 1'b0; per_rdata = '0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt",     {30'b0, m0_gnt, m1_gnt}, 32'h0);
        chk("rst_rvalid",  {28'b0, m0_rvalid, m1_rvalid, m0_err, m1_err}, 32'h0);
        chk("rst_rdata",   m0_rdata | m1_rdata, 32'h0);
        chk("rst_strobes", {29'b0, per_req, ram_we, rom_rden}, 32'h0);
        chk("rst_per",     {20'b0, per_addr} | per_wdata | {28'b0, per_byteen} | {31'b0, per_we}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // single-cycle accesses from the table
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].mst, vecs[i].we, vecs[i].addr, vecs[i].byteen, vecs[i].wdata);
            @(negedge clk);
            chk({vecs[i].name, "_gnt"}, {30'b0, m0_gnt, m1_gnt}, vecs[i].mst ? 32'h1 : 32'h2);
            chk({vecs[i].name, "_strobe"}, {30'b0, ram_we, rom_rden}, {30'b0, vecs[i].ram_we, vecs[i].rom_rden});
            if (vecs[i].tgt == 1) chk({vecs[i].name, "_ram_addr"}, {17'b0, ram_addr}, {16'b0, vecs[i].waddr});
            if (vecs[i].tgt == 2) chk({vecs[i].name, "_rom_addr"}, {16'b0, rom_addr}, {16'b0, vecs[i].waddr});
            if (vecs[i].ram_we) begin
                chk({vecs[i].name, "_ram_wdata"}, ram_wdata, vecs[i].wdata);
                chk({vecs[i].name, "_ram_byteen"}, {28'b0, ram_byteen}, {28'b0, vecs[i].byteen});
            end
            push(vecs[i].mst, vecs[i].rdata, vecs[i].err);
            @(posedge clk); #1;
            release_all();
            @(negedge clk);
            chk({vecs[i].name, "_lat"}, {30'b0, m0_rvalid, m1_rvalid}, vecs[i].mst ? 32'h1 : 32'h2);
            chk({vecs[i].name, "_no_per"}, {31'b0, per_req}, 32'h0);
        end

        // round robin: both masters read ROM continuously, m0 first after reset
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 0, 32'h0000_0010, 4'hF, 32'h0);
        drive(1, 0, 32'h0000_0010, 4'hF, 32'h0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c % 2 == 0) begin
                chk("rr_gnt", {30'b0, m0_gnt, m1_gnt}, ((c / 2) % 2 == 0) ? 32'h2 : 32'h1);
                chk("rr_rom_addr", {16'b0, rom_addr}, 32'h4);
                push(((c / 2) % 2) == 1, 32'hCAFE_0001, 1'b0);
            end else begin
                chk("rr_gap", {30'b0, m0_gnt, m1_gnt}, 32'h0);
            end
            chk("rr_rden", {31'b0, rom_rden}, (c % 2 == 0) ? 32'h1 : 32'h0);
            @(posedge clk); #1;
        end
        release_all();

        // peripheral write, per_ready in the third PWAIT cycle
        @(posedge clk); #1;
        per_rdata = 32'hBAD0_BAD0;
        drive(0, 1, 32'h2000_0008, 4'hF, 32'h1234_5678);
        @(negedge clk);
        chk("pw_gnt", {30'b0, m0_gnt, m1_gnt}, 32'h2);
        chk("pw_req_t0", {29'b0, per_req, ram_we, rom_rden}, 32'h0);
        push(0, 32'h0, 1'b0);
        @(posedge clk); #1;
        release_all();
        for (int k = 1; k <= 4; k++) begin
            per_ready = (k == 3);
            @(negedge clk);
            chk("pw_req", {31'b0, per_req}, (k <= 3) ? 32'h1 : 32'h0);
            chk("pw_rvalid", {31'b0, m0_rvalid}, (k == 4) ? 32'h1 : 32'h0);
            if (k <= 3) begin
                chk("pw_addr", {20'b0, per_addr}, 32'h8);
                chk("pw_fields", {per_wdata[31:4], per_byteen}, {28'h1234_567, 4'hF});
                chk("pw_we", {31'b0, per_we}, 32'h1);
            end
            @(posedge clk); #1;
        end
        per_ready = 1'b0;

        // peripheral read, ready on first wait cycle
        drive(1, 0, 32'h2000_0FFC, 4'hF, 32'h0);
        @(negedge clk);
        chk("pr_gnt", {30'b0, m0_gnt, m1_gnt}, 32'h1);
        push(1, 32'hA5A5_5A5A, 1'b0);
        @(posedge clk); #1;
        release_all();
        per_ready = 1'b1; per_rdata = 32'hA5A5_5A5A;
        @(negedge clk);
        chk("pr_req", {31'b0, per_req}, 32'h1);
        chk("pr_addr", {20'b0, per_addr}, 32'hFFC);
        @(posedge clk); #1;
        per_ready = 1'b0; per_rdata = 32'h0;
        @(negedge clk);
        chk("pr_rvalid", {30'b0, m0_rvalid, m1_rvalid}, 32'h1);
        chk("pr_req_drop", {31'b0, per_req}, 32'h0);

        // peripheral timeout (TIMEOUT=4): rvalid at T+5 with err
        @(posedge clk); #1;
        drive(1, 0, 32'h2000_0010, 4'hF, 32'h0);
        @(negedge clk);
        chk("to_gnt", {30'b0, m0_gnt, m1_gnt}, 32'h1);
        push(1, 32'h0, 1'b1);
        @(posedge clk); #1;
        release_all();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("to_req", {31'b0, per_req}, (k <= 4) ? 32'h1 : 32'h0);
            chk("to_rvalid", {31'b0, m1_rvalid}, (k == 5) ? 32'h1 : 32'h0);
            @(posedge clk); #1;
        end

        // reset during PWAIT of an m0 access: no response, tie goes back to m0
        drive(0, 0, 32'h2000_0004, 4'hF, 32'h0);
        @(negedge clk);
        chk("rp_gnt", {30'b0, m0_gnt, m1_gnt}, 32'h2);
        @(posedge clk); #1;
        release_all();
        rst = 1'b1;
        @(negedge clk);
        chk("rp_req_before", {31'b0, per_req}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rp_req_after", {31'b0, per_req}, 32'h0);
        chk("rp_no_resp", {30'b0, m0_rvalid, m1_rvalid}, 32'h0);
        @(posedge clk); #1;
        drive(0, 0, 32'h1000_0004, 4'hF, 32'h0);
        drive(1, 0, 32'h1000_0004, 4'hF, 32'h0);
        @(negedge clk);
        chk("rp_tie_gnt", {30'b0, m0_gnt, m1_gnt}, 32'h2);
        push(0, 32'hDEAD_BEEF, 1'b0);
        @(posedge clk); #1;
        release_all();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
